pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator for the 32-bit RISC core. It is the next generation of the simple reset/load PC register.
- Produces the fetch address and a valid flag toward instruction fetch, using a valid/ready handshake.
- Resolves the next PC from sequential increment, branch, jump, trap and trap-return requests, in fixed priority.
- Supports halt/resume and flags misaligned redirect targets.

Parameters:
- WIDTH, 32: PC/address width in bits.
- RESET_VECTOR, 32'h0000_0000: first fetch address after reset.
- TRAP_VECTOR, 32'h0000_0100: target on trap or misaligned redirect.
- INSTR_BYTES, 4: sequential increment. Must be a power of two, ≥1.
- ALIGN_BITS, log2(INSTR_BYTES): low target bits that must be zero.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_ready  in  1  fetch accepts the current pc this cycle.
- stall  in  1  hold the pc (pipeline hazard).
- branch_taken  in  1  conditional branch resolved taken.
- branch_target  in  WIDTH  branch destination.
- jump  in  1  unconditional jump.
- jump_target  in  WIDTH  jump destination.
- trap  in  1  exception/interrupt request.
- mret  in  1  return from trap.
- epc_in  in  WIDTH  return address for mret.
- halt_req  in  1  request halt.
- resume  in  1  leave halt.
- pc  out  WIDTH  current fetch address (registered).
- pc_valid  out  1  pc is a valid fetch request.
- redirect  out  1  one-cycle pulse: pc was redirected; fetch flushes in-flight words.
- misalign_err  out  1  one-cycle pulse: misaligned target detected.
- bad_addr  out  WIDTH  last misaligned target (sticky until the next error).
- halted  out  1  block is in HALT.

Behaviour:
- Reset (rst=0, asynchronous): state=BOOT, pc=RESET_VECTOR, pc_valid=0, redirect=0, misalign_err=0, bad_addr=0, halted=0.
- BOOT: exactly one cycle after rst deasserts, with pc_valid=0. Then go to RUN with pc_valid=1 and pc unchanged (RESET_VECTOR).
- RUN, next-pc priority, highest first:
  1. trap → TRAP_VECTOR.
  2. mret → epc_in.
  3. jump → jump_target.
  4. branch_taken → branch_target.
  5. stall → hold.
  6. pc_valid && if_ready → pc+INSTR_BYTES.
  7. Otherwise hold.
- Redirects (levels 1-4) take effect the next cycle regardless of if_ready and stall, and assert redirect for one cycle.
- Misalignment: if the selected redirect target has any of its low ALIGN_BITS bits set:
  - pc loads TRAP_VECTOR, misalign_err pulses, bad_addr captures the offending target, redirect pulses.
  - TRAP_VECTOR itself is never checked.
- Arithmetic: increment is modulo 2^WIDTH. pc=2^WIDTH-INSTR_BYTES wraps to 0 with no flag.
- Halt:
  - halt_req in RUN (and no trap that cycle) → HALT next cycle: pc_valid=0, halted=1, pc held.
  - A redirect in the same cycle as halt_req is applied to pc first, then the block halts.
- HALT:
  - resume → RUN next cycle: pc_valid=1, same pc.
  - trap → RUN with pc=TRAP_VECTOR and redirect pulse (wakes the core).
  - All other inputs are ignored.
- halt_req and resume asserted together in RUN: halt wins. The same pair in HALT: resume wins.
- Reset mid-operation: immediate return to the reset values above, whatever the state.
- pc changes only on the clock edge. All outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- Shared package (core_pkg): XLEN=32, RESET_VECTOR, TRAP_VECTOR, INSTR_BYTES, and a pc_state_t enum {BOOT, RUN, HALT} (2-bit).
- One sub-module, pc_next_sel: combinational priority mux plus alignment check. Outputs: next pc, redirect flag, misalign flag.
- pc_gen holds the registers and the FSM.

Test Plan:
1. Reset release with if_ready=1 → pc_valid=0 for 1 cycle, then pc = 0x0, 0x4, 0x8, 0xC on successive cycles.
2. Hold conditions:
   - stall=1 for 3 cycles at pc=0x10 → pc holds 0x10.
   - if_ready=0 alone → pc holds.
   - Release → 0x14.
3. Priority and wake-up:
   - trap, jump (0x200) and branch (0x300) in the same cycle → pc=0x100 next, redirect pulse 1 cycle.
   - Then mret with epc_in=0x44 → pc=0x44.
4. jump_target=0x202 → pc=0x100, misalign_err=1 for 1 cycle, bad_addr=0x202. Then branch_target=0x400 → pc=0x400, bad_addr still 0x202.
5. Halt/resume:
   - halt_req at pc=0x20 → halted=1, pc_valid=0, pc=0x20 while if_ready=1.
   - resume → next cycle pc_valid=1, pc=0x20, then 0x24.
   - While halted, trap → pc=0x100, halted=0.
6. Wrap and async reset:
   - Force pc=0xFFFF_FFFC with if_ready=1 → pc=0x0.
   - Pulse rst low mid-cycle → pc=RESET_VECTOR and pc_valid=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the 32-bit core's program-counter path.
package core_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_TRAP_VECTOR  = 32'h0000_0100;
    localparam int              DEF_INSTR_BYTES  = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: trap > mret > jump > branch > stall > sequential > hold,
// with the alignment check applied to the chosen redirect target.
module pc_next_sel
    import core_pkg::*;
#(
    parameter int               WIDTH       = XLEN,
    parameter logic [WIDTH-1:0] TRAP_VECTOR = WIDTH'(DEF_TRAP_VECTOR),
    parameter int               INSTR_BYTES = DEF_INSTR_BYTES,
    parameter int               ALIGN_BITS  = $clog2(INSTR_BYTES)
) (
    input  logic [WIDTH-1:0] i_pc,
    input  logic             i_pc_valid,
    input  logic             i_if_ready,
    input  logic             i_stall,
    input  logic             i_trap,
    input  logic             i_mret,
    input  logic [WIDTH-1:0] i_epc,
    input  logic             i_jump,
    input  logic [WIDTH-1:0] i_jump_target,
    input  logic             i_branch_taken,
    input  logic [WIDTH-1:0] i_branch_target,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_target,
    output logic             o_redirect,
    output logic             o_misalign
);

    // A mask rather than a slice keeps ALIGN_BITS == 0 (byte-sized instructions) legal.
    localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);

    logic [WIDTH-1:0] w_target;

    always_comb begin
        // NOTE: every output gets a default before the branches, so no path leaves one unassigned and no latch is inferred.
        w_target   = i_mret ? i_epc : (i_jump ? i_jump_target : i_branch_target);
        o_pc       = i_pc;
        o_target   = '0;
        o_redirect = 1'b0;
        o_misalign = 1'b0;
        if (i_trap) begin
            o_pc       = TRAP_VECTOR;
            o_redirect = 1'b1;
        end else if (i_mret || i_jump || i_branch_taken) begin
            o_target   = w_target;
            o_redirect = 1'b1;
            if (|(w_target & ALIGN_MASK)) begin
                o_pc       = TRAP_VECTOR;
                o_misalign = 1'b1;
            end else begin
                o_pc = w_target;
            end
        end else if (!i_stall && i_pc_valid && i_if_ready) begin
            o_pc = i_pc + WIDTH'(INSTR_BYTES);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALT sequencing around pc_next_sel,
// with every output driven straight from a register.
module pc_gen
    import core_pkg::*;
#(
    parameter int               WIDTH        = XLEN,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(DEF_TRAP_VECTOR),
    parameter int               INSTR_BYTES  = DEF_INSTR_BYTES,
    parameter int               ALIGN_BITS   = $clog2(INSTR_BYTES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_ready,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             trap,
    input  logic             mret,
    input  logic [WIDTH-1:0] epc_in,
    input  logic             halt_req,
    input  logic             resume,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             redirect,
    output logic             misalign_err,
    output logic [WIDTH-1:0] bad_addr,
    output logic             halted
);

    pc_state_t        r_state, w_state_nxt;
    logic [WIDTH-1:0] r_pc, w_pc_nxt;
    logic [WIDTH-1:0] r_bad_addr, w_bad_addr_nxt;
    logic             r_redirect, w_redirect_nxt;
    logic             r_misalign, w_misalign_nxt;

    logic [WIDTH-1:0] w_sel_pc, w_sel_target;
    logic             w_sel_redirect, w_sel_misalign;
    logic             w_pc_valid;

    assign w_pc_valid = (r_state == RUN);

    // A pending halt freezes the sequential advance; redirects still land first.
    pc_next_sel #(
        .WIDTH       (WIDTH),
        .TRAP_VECTOR (TRAP_VECTOR),
        .INSTR_BYTES (INSTR_BYTES),
        .ALIGN_BITS  (ALIGN_BITS)
    ) u_next_sel (
        .i_pc            (r_pc),
        .i_pc_valid      (w_pc_valid),
        .i_if_ready      (if_ready),
        .i_stall         (stall | halt_req),
        .i_trap          (trap),
        .i_mret          (mret),
        .i_epc           (epc_in),
        .i_jump          (jump),
        .i_jump_target   (jump_target),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .o_pc            (w_sel_pc),
        .o_target        (w_sel_target),
        .o_redirect      (w_sel_redirect),
        .o_misalign      (w_sel_misalign)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_bad_addr_nxt = r_bad_addr;
        w_redirect_nxt = 1'b0;
        w_misalign_nxt = 1'b0;
        case (r_state)
            BOOT: w_state_nxt = RUN;
            RUN: begin
                w_pc_nxt       = w_sel_pc;
                w_redirect_nxt = w_sel_redirect;
                w_misalign_nxt = w_sel_misalign;
                if (w_sel_misalign) w_bad_addr_nxt = w_sel_target;
                if (halt_req && !trap) w_state_nxt = HALT;
            end
            HALT: begin
                // Only trap or resume can wake the block; trap also redirects.
                if (trap) begin
                    w_pc_nxt       = w_sel_pc;
                    w_redirect_nxt = 1'b1;
                    w_state_nxt    = RUN;
                end else if (resume) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= BOOT;
            r_pc       <= RESET_VECTOR;
            r_bad_addr <= '0;
            r_redirect <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_bad_addr <= w_bad_addr_nxt;
            r_redirect <= w_redirect_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    assign pc           = r_pc;
    assign pc_valid     = w_pc_valid;
    assign redirect     = r_redirect;
    assign misalign_err = r_misalign;
    assign bad_addr     = r_bad_addr;
    assign halted       = (r_state == HALT);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, hand-written reset
// sequence, and randomized traffic against a behavioural model.
module tb_pc_gen;

    localparam logic [31:0] TV = 32'h0000_0100;

    localparam logic [7:0] F_RDY = 8'h01, F_STL = 8'h02, F_BR = 8'h04, F_JP = 8'h08,
                           F_TR  = 8'h10, F_MR  = 8'h20, F_HR = 8'h40, F_RS = 8'h80;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ready, stall, branch_taken, jump, trap, mret, halt_req, resume;
    logic [31:0] branch_target, jump_target, epc_in;
    logic [31:0] pc, bad_addr;
    logic        pc_valid, redirect, misalign_err, halted;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk           (clk),
        .rst           (rst),
        .if_ready      (if_ready),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .trap          (trap),
        .mret          (mret),
        .epc_in        (epc_in),
        .halt_req      (halt_req),
        .resume        (resume),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .redirect      (redirect),
        .misalign_err  (misalign_err),
        .bad_addr      (bad_addr),
        .halted        (halted)
    );

    // One vector: inputs held for one cycle, outputs expected after the next edge.
    // eo = {pc_valid, redirect, misalign_err, halted}
    typedef struct {
        logic [7:0]  f;
        logic [31:0] a, b, e;
        logic [31:0] pc;
        logic [3:0]  eo;
        logic [31:0] bad;
    } vec_t;

    vec_t tbl[38];

    function automatic vec_t mk(logic [7:0] f, logic [31:0] a, logic [31:0] b, logic [31:0] e,
                                logic [31:0] epc_v, logic [3:0] eo, logic [31:0] bad);
        vec_t v;
        v.f = f; v.a = a; v.b = b; v.e = e; v.pc = epc_v; v.eo = eo; v.bad = bad;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h, want %08h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] e_pc, input logic [3:0] eo,
                              input logic [31:0] e_bad);
        check({tag, " pc"},           pc,                   e_pc);
        check({tag, " pc_valid"},     {31'd0, pc_valid},    {31'd0, eo[3]});
        check({tag, " redirect"},     {31'd0, redirect},    {31'd0, eo[2]});
        check({tag, " misalign_err"}, {31'd0, misalign_err}, {31'd0, eo[1]});
        check({tag, " halted"},       {31'd0, halted},      {31'd0, eo[0]});
        check({tag, " bad_addr"},     bad_addr,             e_bad);
    endtask

    task automatic apply(input logic [7:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e);
        if_ready      = f[0];
        stall         = f[1];
        branch_taken  = f[2];
        jump          = f[3];
        trap          = f[4];
        mret          = f[5];
        halt_req      = f[6];
        resume        = f[7];
        jump_target   = a;
        branch_target = b;
        epc_in        = e;
    endtask

    // Behavioural model: mode 0 = boot, 1 = running, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc, m_bad;
    logic        m_redir, m_mis;

    task automatic model_edge(input logic [7:0] f, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] e);
        logic [31:0] tgt;
        m_redir = 1'b0;
        m_mis   = 1'b0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 2) begin
            if (f[4]) begin
                m_pc = TV; m_redir = 1'b1; m_mode = 1;
            end else if (f[7]) begin
                m_mode = 1;
            end
        end else begin
            if (f[4]) begin
                m_pc = TV; m_redir = 1'b1;
            end else if (f[5] || f[3] || f[2]) begin
                tgt = f[5] ? e : (f[3] ? a : b);
                m_redir = 1'b1;
                if (tgt % 4 != 0) begin
                    m_pc = TV; m_mis = 1'b1; m_bad = tgt;
                end else begin
                    m_pc = tgt;
                end
            end else if (!f[1] && !f[6] && f[0]) begin
                m_pc = m_pc + 32'd4;
            end
            if (f[6] && !f[4]) m_mode = 2;
        end
    endtask

    initial begin
        logic [7:0]  f;
        logic [31:0] a, b, e;

        tbl[0]  = mk(F_RDY,               0, 0, 0, 32'h0,  4'b1000, 0);
        tbl[1]  = mk(F_RDY,               0, 0, 0, 32'h4,  4'b1000, 0);
        tbl[2]  = mk(F_RDY,               0, 0, 0, 32'h8,  4'b1000, 0);
        tbl[3]  = mk(F_RDY,               0, 0, 0, 32'hC,  4'b1000, 0);
        tbl[4]  = mk(F_RDY,               0, 0, 0, 32'h10, 4'b1000, 0);
        tbl[5]  = mk(F_RDY | F_STL,       0, 0, 0, 32'h10, 4'b1000, 0);
        tbl[6]  = mk(F_RDY | F_STL,       0, 0, 0, 32'h10, 4'b1000, 0);
        tbl[7]  = mk(F_RDY | F_STL,       0, 0, 0, 32'h10, 4'b1000, 0);
        tbl[8]  = mk(8'h00,               0, 0, 0, 32'h10, 4'b1000, 0);
        tbl[9]  = mk(F_RDY,               0, 0, 0, 32'h14, 4'b1000, 0);
        tbl[10] = mk(F_RDY|F_TR|F_JP|F_BR, 32'h200, 32'h300, 0, TV, 4'b1100, 0);
        tbl[11] = mk(F_RDY,               0, 0, 0, 32'h104, 4'b1000, 0);
        tbl[12] = mk(F_RDY | F_MR,        0, 0, 32'h44, 32'h44, 4'b1100, 0);
        tbl[13] = mk(F_RDY | F_JP,        32'h202, 0, 0, TV, 4'b1110, 32'h202);
        tbl[14] = mk(F_RDY | F_BR,        0, 32'h400, 0, 32'h400, 4'b1100, 32'h202);
        tbl[15] = mk(F_RDY,               0, 0, 0, 32'h404, 4'b1000, 32'h202);
        tbl[16] = mk(F_RDY | F_JP,        32'h20, 0, 0, 32'h20, 4'b1100, 32'h202);
        tbl[17] = mk(F_RDY | F_HR,        0, 0, 0, 32'h20, 4'b0001, 32'h202);
        tbl[18] = mk(F_RDY,               0, 0, 0, 32'h20, 4'b0001, 32'h202);
        tbl[19] = mk(F_RDY | F_JP,        32'h80, 0, 0, 32'h20, 4'b0001, 32'h202);
        tbl[20] = mk(F_RDY | F_RS,        0, 0, 0, 32'h20, 4'b1000, 32'h202);
        tbl[21] = mk(F_RDY,               0, 0, 0, 32'h24, 4'b1000, 32'h202);
        tbl[22] = mk(F_RDY | F_HR | F_RS, 0, 0, 0, 32'h24, 4'b0001, 32'h202);
        tbl[23] = mk(F_RDY | F_HR | F_RS, 0, 0, 0, 32'h24, 4'b1000, 32'h202);
        tbl[24] = mk(F_RDY | F_HR,        0, 0, 0, 32'h24, 4'b0001, 32'h202);
        tbl[25] = mk(F_RDY | F_TR,        0, 0, 0, TV, 4'b1100, 32'h202);
        tbl[26] = mk(F_RDY | F_JP | F_HR, 32'h500, 0, 0, 32'h500, 4'b0101, 32'h202);
        tbl[27] = mk(F_RDY | F_TR | F_RS, 0, 0, 0, TV, 4'b1100, 32'h202);
        tbl[28] = mk(F_RDY | F_TR | F_HR, 0, 0, 0, TV, 4'b1100, 32'h202);
        tbl[29] = mk(F_RDY | F_MR,        0, 0, 32'h41, TV, 4'b1110, 32'h41);
        tbl[30] = mk(F_RDY,               0, 0, 0, 32'h104, 4'b1000, 32'h41);
        tbl[31] = mk(F_RDY | F_JP,        32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 4'b1100, 32'h41);
        tbl[32] = mk(F_RDY,               0, 0, 0, 32'h0, 4'b1000, 32'h41);
        tbl[33] = mk(F_RDY | F_STL,       0, 32'h888, 0, 32'h0, 4'b1000, 32'h41);
        tbl[34] = mk(F_RDY|F_MR|F_JP|F_BR, 32'h200, 32'h300, 32'h60, 32'h60, 4'b1100, 32'h41);
        tbl[35] = mk(F_RDY | F_JP | F_BR, 32'h208, 32'h30C, 0, 32'h208, 4'b1100, 32'h41);
        tbl[36] = mk(F_BR | F_STL,        0, 32'h3, 0, TV, 4'b1110, 32'h3);
        tbl[37] = mk(8'h00,               0, 0, 0, TV, 4'b1000, 32'h3);

        // Reset and BOOT
        rst = 1'b0;
        apply(F_RDY, 0, 0, 0);
        #2;
        check_outs("reset", 32'h0, 4'b0000, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        check_outs("boot", 32'h0, 4'b0000, 32'h0);

        // Directed table
        for (int i = 0; i < 38; i++) begin
            apply(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].e);
            @(posedge clk); #1;
            check_outs($sformatf("vec%0d", i), tbl[i].pc, tbl[i].eo, tbl[i].bad);
        end

        // Asynchronous reset mid-cycle, well before the next rising edge
        apply(F_RDY | F_JP, 32'h300, 0, 0);
        @(posedge clk); #1;
        check_outs("pre_rst", 32'h300, 4'b1100, 32'h3);
        apply(F_RDY, 0, 0, 0);
        #3;
        rst = 1'b0;
        #1;
        check_outs("async_rst", 32'h0, 4'b0000, 32'h0);
        @(posedge clk); #1;
        check_outs("rst_held", 32'h0, 4'b0000, 32'h0);
        rst = 1'b1;

        // Randomized traffic against the model
        m_mode = 0; m_pc = 32'h0; m_bad = 32'h0; m_redir = 1'b0; m_mis = 1'b0;
        for (int n = 0; n < 600; n++) begin
            f = 8'h00;
            f[0] = ($urandom_range(3) != 0);
            f[1] = ($urandom_range(4) == 0);
            f[2] = ($urandom_range(5) == 0);
            f[3] = ($urandom_range(7) == 0);
            f[4] = ($urandom_range(15) == 0);
            f[5] = ($urandom_range(11) == 0);
            f[6] = ($urandom_range(9) == 0);
            f[7] = ($urandom_range(2) == 0);
            a = $urandom; b = $urandom; e = $urandom;
            if ($urandom_range(3) != 0) a[1:0] = 2'b00;
            if ($urandom_range(3) != 0) b[1:0] = 2'b00;
            if ($urandom_range(3) != 0) e[1:0] = 2'b00;
            apply(f, a, b, e);
            @(posedge clk);
            model_edge(f, a, b, e);
            #1;
            check_outs($sformatf("rnd%0d", n), m_pc,
                       {(m_mode == 1), m_redir, m_mis, (m_mode == 2)}, m_bad);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
